// File: rtl/qpsk_pkg.sv
// Shared definitions for the QPSK framer and its receive-side companion.
// chk8 is the one checksum definition both sides agree on.
package qpsk_pkg;

    localparam logic [7:0] HEADER_DEF = 8'hcc;
    localparam int         FRAME_BITS = 56;
    localparam int         FRAME_SYM  = 28;
    localparam int         PAY_W      = 40;

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        PREAMBLE,
        FRAME,
        GAP
    } state_t;

    // Byte-wise sum with 8-bit wraparound.
    function automatic logic [7:0] chk8(input logic [PAY_W-1:0] payload);
        logic [7:0] s;
        s = 8'h00;
        for (int i = 0; i < PAY_W / 8; i++) begin
            s = s + payload[i*8 +: 8];
        end
        return s;
    endfunction

endpackage

// File: rtl/qpsk_sym_timer.sv
// Free-running symbol timer: counts 0..SAMPLE-1 forever, restarted only by reset.
// o_sym_strobe is registered so it is high exactly while the count is 0.
module qpsk_sym_timer #(
    parameter int SAMPLE = 100,
    parameter int CW     = $clog2(SAMPLE)
) (
    input  logic clk,
    input  logic rst_n,
    output logic o_sym_strobe,
    output logic o_last_clk,
    output logic o_pre_last
);

    localparam logic [CW-1:0] LAST     = CW'(SAMPLE - 1);
    localparam logic [CW-1:0] PRE_LAST = CW'(SAMPLE - 2);

    logic [CW-1:0] r_sym_cnt;
    logic          r_strobe;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sym_cnt <= '0;
            r_strobe  <= 1'b0;
        end else begin
            r_sym_cnt <= (r_sym_cnt == LAST) ? '0 : r_sym_cnt + 1'b1;
            r_strobe  <= (r_sym_cnt == LAST);
        end
    end

    assign o_sym_strobe = r_strobe;
    assign o_last_clk   = (r_sym_cnt == LAST);
    assign o_pre_last   = (r_sym_cnt == PRE_LAST);

endmodule

// File: rtl/qpsk_frame_tx.sv
// QPSK transmit framer: preamble, header, payload and checksum as I/Q bit pairs,
// each symbol held SAMPLE clocks and aligned to the free-running symbol timer.
module qpsk_frame_tx
    import qpsk_pkg::*;
#(
    parameter logic [7:0] HEADER  = HEADER_DEF,
    parameter int         SAMPLE  = 100,
    parameter int         PRE_SYM = 16,
    parameter int         GAP_SYM = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [PAY_W-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             ser_I,
    output logic             ser_Q,
    output logic             sym_strobe,
    output logic             busy,
    output logic             frame_done
);

    localparam int MAX_SYM = (PRE_SYM > GAP_SYM)
                           ? ((PRE_SYM > FRAME_SYM) ? PRE_SYM : FRAME_SYM)
                           : ((GAP_SYM > FRAME_SYM) ? GAP_SYM : FRAME_SYM);
    localparam int IW = $clog2(MAX_SYM + 1);

    localparam logic [IW-1:0] PRE_LAST = IW'((PRE_SYM > 0) ? PRE_SYM - 1 : 0);
    localparam logic [IW-1:0] FRM_LAST = IW'(FRAME_SYM - 1);
    localparam logic [IW-1:0] GAP_LAST = IW'((GAP_SYM > 0) ? GAP_SYM - 1 : 0);

    logic w_last_clk;
    logic w_pre_last;
    logic w_hs;

    state_t                r_state;
    logic [FRAME_BITS-1:0] r_sr;
    logic [IW-1:0]         r_idx;
    logic                  r_I;
    logic                  r_Q;
    logic                  r_ready;
    logic                  r_busy;
    logic                  r_done;

    qpsk_sym_timer #(
        .SAMPLE(SAMPLE)
    ) u_timer (
        .clk         (clk),
        .rst_n       (rst_n),
        .o_sym_strobe(sym_strobe),
        .o_last_clk  (w_last_clk),
        .o_pre_last  (w_pre_last)
    );

    assign w_hs = din_valid & r_ready;

    // Every symbol change happens on the edge closing sym_cnt==SAMPLE-1,
    // so the new value is visible for the whole of the next symbol.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_sr    <= '0;
            r_idx   <= '0;
            r_I     <= 1'b0;
            r_Q     <= 1'b0;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= (r_state == FRAME) && (r_idx == FRM_LAST) && w_pre_last;
            case (r_state)
                IDLE: begin
                    if (w_hs) begin
                        r_sr    <= {HEADER, din, chk8(din)};
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= ARMED;
                    end
                end
                ARMED: begin
                    if (w_last_clk) begin
                        r_idx <= '0;
                        if (PRE_SYM > 0) begin
                            r_state <= PREAMBLE;
                            r_I     <= 1'b1;
                            r_Q     <= 1'b0;
                        end else begin
                            r_state    <= FRAME;
                            {r_I, r_Q} <= r_sr[FRAME_BITS-1 -: 2];
                            r_sr       <= r_sr << 2;
                        end
                    end
                end
                PREAMBLE: begin
                    if (w_last_clk) begin
                        if (r_idx == PRE_LAST) begin
                            r_state    <= FRAME;
                            r_idx      <= '0;
                            {r_I, r_Q} <= r_sr[FRAME_BITS-1 -: 2];
                            r_sr       <= r_sr << 2;
                        end else begin
                            // Swapping I and Q walks the (1,0),(0,1) alternation.
                            r_idx <= r_idx + 1'b1;
                            r_I   <= r_Q;
                            r_Q   <= r_I;
                        end
                    end
                end
                FRAME: begin
                    if (w_last_clk) begin
                        if (r_idx == FRM_LAST) begin
                            r_idx <= '0;
                            r_I   <= 1'b0;
                            r_Q   <= 1'b0;
                            if (GAP_SYM > 0) begin
                                r_state <= GAP;
                            end else begin
                                r_state <= IDLE;
                                r_ready <= 1'b1;
                                r_busy  <= 1'b0;
                            end
                        end else begin
                            r_idx      <= r_idx + 1'b1;
                            {r_I, r_Q} <= r_sr[FRAME_BITS-1 -: 2];
                            r_sr       <= r_sr << 2;
                        end
                    end
                end
                GAP: begin
                    if (w_last_clk) begin
                        if (r_idx == GAP_LAST) begin
                            r_idx   <= '0;
                            r_state <= IDLE;
                            r_ready <= 1'b1;
                            r_busy  <= 1'b0;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign din_ready  = r_ready;
    assign ser_I      = r_I;
    assign ser_Q      = r_Q;
    assign busy       = r_busy;
    assign frame_done = r_done;

endmodule

// File: tb/tb_qpsk_frame_tx.sv
// Directed bench for qpsk_frame_tx: table of frames with hand-computed checksums,
// plus reset and mid-frame reset sequences. Two instances cover PRE/GAP = 16/8 and 0/0.
module tb_qpsk_frame_tx;
    import qpsk_pkg::*;

    localparam int SAMPLE = 100;
    localparam int PRE    = 16;
    localparam int GAPS   = 8;

    typedef struct {
        logic [39:0] din;
        logic [7:0]  chk;
        int          ph;
        bit          hold;
        bit          dut2;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [39:0] din = '0;
    logic        v1 = 1'b0, v2 = 1'b0;
    logic        rdy1, i1, q1, stb1, busy1, done1;
    logic        rdy2, i2, q2, stb2, busy2, done2;
    logic        rdy, si, sq, stb, bsy, dn;
    bit          sel = 1'b0;
    int          ph = 0;
    int          n_chk = 0;
    int          n_pass = 0;
    int          done_cnt = 0;
    vec_t        tbl[6];

    always #5 clk = ~clk;

    qpsk_frame_tx #(.SAMPLE(SAMPLE), .PRE_SYM(PRE), .GAP_SYM(GAPS)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(v1), .din_ready(rdy1),
        .ser_I(i1), .ser_Q(q1), .sym_strobe(stb1), .busy(busy1), .frame_done(done1)
    );

    qpsk_frame_tx #(.SAMPLE(SAMPLE), .PRE_SYM(0), .GAP_SYM(0)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(v2), .din_ready(rdy2),
        .ser_I(i2), .ser_Q(q2), .sym_strobe(stb2), .busy(busy2), .frame_done(done2)
    );

    assign rdy = sel ? rdy2  : rdy1;
    assign si  = sel ? i2    : i1;
    assign sq  = sel ? q2    : q1;
    assign stb = sel ? stb2  : stb1;
    assign bsy = sel ? busy2 : busy1;
    assign dn  = sel ? done2 : done1;

    always @(negedge clk) begin
        if (rst_n && dn) done_cnt <= done_cnt + 1;
    end

    task automatic tick();
        @(negedge clk);
        ph = (ph + 1) % SAMPLE;
    endtask

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    task automatic run_frame(input vec_t v);
        logic [55:0] bits;
        logic [1:0]  e;
        int          pre, gap, k, nd, j;
        bits = {8'hCC, v.din, v.chk};
        pre  = v.dut2 ? 0 : PRE;
        gap  = v.dut2 ? 0 : GAPS;
        sel  = v.dut2;
        for (int w = 0; w < SAMPLE && ph != v.ph; w++) tick();
        din = v.din;
        if (v.dut2) v2 = 1'b1; else v1 = 1'b1;
        check("ready_at_handshake", {rdy, bsy}, 2'b10);
        nd = done_cnt;
        tick();
        check("busy_after_capture", {rdy, bsy}, 2'b01);
        din = ~v.din ^ 40'h5A_A5_3C_C3_0F;
        if (!v.hold) begin
            v1 = 1'b0;
            v2 = 1'b0;
        end
        k = (SAMPLE - v.ph) + ((v.ph == SAMPLE - 1) ? SAMPLE : 0);
        repeat (k - 2) tick();
        check("idle_before_first_sym", {si, sq}, 2'b00);
        tick();
        for (int s = 0; s < pre + FRAME_SYM + gap; s++) begin
            if (s < pre) begin
                e = (s % 2 == 0) ? 2'b10 : 2'b01;
            end else if (s < pre + FRAME_SYM) begin
                j = s - pre;
                e = {bits[55-2*j], bits[54-2*j]};
            end else begin
                e = 2'b00;
            end
            check($sformatf("sym%0d_first_clk", s), {stb, si, sq}, {1'b1, e});
            repeat (SAMPLE - 1) tick();
            check($sformatf("sym%0d_last_clk", s), {stb, si, sq, dn},
                  {1'b0, e, 1'(s == pre + FRAME_SYM - 1)});
            tick();
        end
        check("idle_after_frame", {rdy, bsy, si, sq}, 4'b1000);
        check("frame_done_count", done_cnt - nd, 1);
    endtask

    initial begin
        tbl[0] = '{40'h12_34_56_78_9A, 8'hAE, 37, 1'b0, 1'b0};
        tbl[1] = '{40'h01_02_03_04_05, 8'h0F, 99, 1'b1, 1'b0};
        tbl[2] = '{40'hA5_5A_A5_5A_FF, 8'hFD,  0, 1'b1, 1'b0};
        tbl[3] = '{40'h80_80_80_80_01, 8'h01,  0, 1'b0, 1'b0};
        tbl[4] = '{40'hFF_FF_FF_FF_FF, 8'hFB, 10, 1'b0, 1'b1};
        tbl[5] = '{40'h00_00_00_00_00, 8'h00,  0, 1'b0, 1'b1};

        // Reset state
        repeat (5) @(negedge clk);
        check("reset_dut1", {rdy1, busy1, i1, q1, stb1, done1}, 6'b100000);
        check("reset_dut2", {rdy2, busy2, i2, q2, stb2, done2}, 6'b100000);
        rst_n = 1'b1;
        ph = 0;
        for (int c = 0; c < 3 * SAMPLE; c++) begin
            check("strobe_period", {stb1, stb2, i1, q1, rdy1},
                  {1'(ph == 0 && c > 0), 1'(ph == 0 && c > 0), 3'b001});
            tick();
        end

        for (int t = 0; t < 6; t++) run_frame(tbl[t]);

        // Reset during FRAME symbol 10 of 12_34_56_78_9A: symbol carries (0,1)
        sel = 1'b0;
        for (int w = 0; w < SAMPLE && ph != 0; w++) tick();
        din = 40'h12_34_56_78_9A;
        v1 = 1'b1;
        tick();
        v1 = 1'b0;
        repeat (SAMPLE * (1 + PRE + 10) + 50 - 1) tick();
        check("mid_frame_sym10", {busy1, i1, q1}, 3'b101);
        begin
            int nd;
            nd = done_cnt;
            rst_n = 1'b0;
            #1;
            check("async_reset_outputs", {rdy1, busy1, i1, q1, stb1, done1}, 6'b100000);
            repeat (5) @(negedge clk);
            rst_n = 1'b1;
            ph = 0;
            repeat (SAMPLE * 30) tick();
            check("no_done_after_reset", done_cnt - nd, 0);
        end
        run_frame(tbl[0]);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
